gpr_port_arbiter: RTL and testbench
===================================

GPR_PORT_ARBITER -- requirements
Module: gpr_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width.
REQ-002 SHALL have parameter NREGS, default 32: register count; address width is log2(NREGS).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports a_req/a_we, input, 1 each: core requester valid and write-enable.
REQ-006 SHALL have ports a_addr (input, 5), a_wdata (input, XLEN), a_gnt (output, 1), a_rdata (output, XLEN), a_rvalid (output, 1): core address, write data, grant, read data, read-data valid.
REQ-007 SHALL have ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata and b_rvalid: debug requester, with the same directions and widths as port A.
REQ-008 SHALL have ports rf_we (output, 1), rf_addr (output, 5), rf_wdata (output, XLEN) and rf_rdata (input, XLEN): the register file port, with a combinational read.
REQ-009 SHALL have port init_done, output, 1: high once register clearing completes.

Function
REQ-010 SHALL implement states INIT and RUN only.
REQ-011 In INIT, SHALL drive rf_we=1, rf_addr=clr_cnt and rf_wdata=0 each cycle, with clr_cnt running 0..NREGS-1.
REQ-012 SHALL move from INIT to RUN in the cycle after clr_cnt=NREGS-1 is written (NREGS cycles in INIT), setting init_done=1.
REQ-013 In INIT, SHALL hold a_gnt=b_gnt=0 whatever the request inputs are.
REQ-014 In RUN, SHALL grant at most one requester per cycle; the grant is combinational in the cycle req is high.
REQ-015 Requesters SHALL hold req/we/addr/wdata stable until gnt is seen; the transfer occurs in the cycle where req&gnt=1.
REQ-016 When only one requester has req=1, SHALL grant that requester.
REQ-017 When both requesters have req=1, SHALL grant the one not granted most recently (round-robin pointer, updated on every grant); after reset the pointer favours A.
REQ-018 A granted write SHALL drive rf_we=1, rf_addr=addr and rf_wdata=wdata in the same cycle.
REQ-019 A granted write to address 0 SHALL complete (gnt=1) with rf_we=0.
REQ-020 A granted read SHALL drive rf_addr=addr with rf_we=0, register rf_rdata, and assert x_rdata and x_rvalid for exactly one cycle on the next cycle (latency 1).
REQ-021 A read of address 0 SHALL return 0 regardless of rf_rdata.
REQ-022 A read granted in the cycle after a write to the same address SHALL return the new value; no bypass is needed because the write commits at the edge.
REQ-023 With no grant in RUN, SHALL hold rf_we=0 and rf_addr=0.
REQ-024 x_rdata SHALL hold its last value when x_rvalid=0.
REQ-025 Worst-case grant wait for a continuously requesting port SHALL be 1 cycle.

Reset
REQ-026 On rst_n=0, SHALL immediately set state=INIT, clr_cnt=0, rr pointer=A, init_done=0, a_rvalid=b_rvalid=0 and a_rdata=b_rdata=0.
REQ-027 While rst_n=0, SHALL hold rf_we=0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart the full clear sequence from address 0 after deassertion; in-flight read responses are discarded.

Structure
REQ-029 SHALL place the XLEN/NREGS defaults, the state encoding (INIT=0, RUN=1) and the requester-id encoding (A=0, B=1) in shared package gpr_pkg.
REQ-030 SHALL implement the 2-way round-robin grant logic as sub-module rr_arb2 (req[1:0], last pointer in; gnt[1:0] out).

Verification
REQ-031 Reset then idle -> rf_we=1 for exactly 32 cycles at addresses 0..31 with data 0; init_done rises on cycle 33; all gnt stay 0 throughout, even with a_req=1.
REQ-032 A writes 0xDEADBEEF to address 5, then A reads address 5 the next cycle -> a_rdata=0xDEADBEEF with a_rvalid=1 one cycle after the read grant.
REQ-033 A and B both request continuously for 6 cycles -> grants alternate A,B,A,B,A,B; neither port waits more than 1 cycle.
REQ-034 B writes 0x12345678 to address 0, then B reads address 0 -> no rf_we pulse during the write; b_rdata=0.
REQ-035 rst_n pulsed low during RUN while a read response is pending -> a_rvalid is 0 after reset, and the clear sequence restarts at address 0.
REQ-036 Single request with the rr pointer favouring the other port -> the lone requester is granted in the same cycle.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared definitions for the GPR port arbiter: default sizes, FSM state encoding
// and requester identifiers.
package gpr_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and on contention
// the requester that was not granted last wins.
module rr_arb2
    import gpr_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == REQ_A) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/gpr_port_arbiter.sv
// Shares one register-file port between a core (A) and a debug (B) requester,
// after first clearing every register to zero out of reset.
module gpr_port_arbiter
    import gpr_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            a_req,
    input  logic            a_we,
    input  logic [AW-1:0]   a_addr,
    input  logic [XLEN-1:0] a_wdata,
    output logic            a_gnt,
    output logic [XLEN-1:0] a_rdata,
    output logic            a_rvalid,

    input  logic            b_req,
    input  logic            b_we,
    input  logic [AW-1:0]   b_addr,
    input  logic [XLEN-1:0] b_wdata,
    output logic            b_gnt,
    output logic [XLEN-1:0] b_rdata,
    output logic            b_rvalid,

    output logic            rf_we,
    output logic [AW-1:0]   rf_addr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [XLEN-1:0] rf_rdata,

    output logic            init_done
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_clr_cnt;
    logic            r_init_done;
    req_id_t         r_last;
    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    logic            w_we;
    logic            w_a_rd;
    logic            w_b_rd;
    logic [XLEN-1:0] w_rd_data;
    logic            r_a_rvalid;
    logic            r_b_rvalid;
    logic [XLEN-1:0] r_a_rdata;
    logic [XLEN-1:0] r_b_rdata;

    // Requests are invisible to the arbiter until the clear sequence is done.
    assign w_req = (r_state == ST_RUN) ? {b_req, a_req} : 2'b00;

    rr_arb2 u_arb (
        .req  (w_req),
        .last (r_last),
        .gnt  (w_gnt)
    );

    assign a_gnt  = w_gnt[0];
    assign b_gnt  = w_gnt[1];
    assign w_a_rd = w_gnt[0] & ~a_we;
    assign w_b_rd = w_gnt[1] & ~b_we;

    // Register 0 reads as zero whatever the register file holds there.
    assign w_rd_data = (rf_addr == '0) ? '0 : rf_rdata;

    always_comb begin
        w_state_next = r_state;
        if (r_state == ST_INIT && r_clr_cnt == LAST_ADDR) begin
            w_state_next = ST_RUN;
        end
    end

    always_comb begin
        w_we     = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        case (r_state)
            ST_INIT: begin
                w_we    = 1'b1;
                rf_addr = r_clr_cnt;
            end
            ST_RUN: begin
                if (w_gnt[1]) begin
                    w_we     = b_we && (b_addr != '0);
                    rf_addr  = b_addr;
                    rf_wdata = b_wdata;
                end else if (w_gnt[0]) begin
                    w_we     = a_we && (a_addr != '0);
                    rf_addr  = a_addr;
                    rf_wdata = a_wdata;
                end
            end
            default: ;
        endcase
    end

    // Gated so no clear write leaks out while reset is still asserted.
    assign rf_we = w_we & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_clr_cnt   <= '0;
            r_init_done <= 1'b0;
            r_last      <= REQ_B;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_INIT) begin
                if (r_clr_cnt == LAST_ADDR) begin
                    r_init_done <= 1'b1;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end
            if (w_gnt[0]) begin
                r_last <= REQ_A;
            end else if (w_gnt[1]) begin
                r_last <= REQ_B;
            end
            r_a_rvalid <= w_a_rd;
            r_b_rvalid <= w_b_rd;
            if (w_a_rd) begin
                r_a_rdata <= w_rd_data;
            end
            if (w_b_rd) begin
                r_b_rdata <= w_rd_data;
            end
        end
    end

    assign a_rvalid  = r_a_rvalid;
    assign b_rvalid  = r_b_rvalid;
    assign a_rdata   = r_a_rdata;
    assign b_rdata   = r_b_rdata;
    assign init_done = r_init_done;

endmodule

// File: tb/tb_gpr_port_arbiter.sv
// Scoreboard bench for gpr_port_arbiter: a behavioural register file sits on the
// rf port, expected read data is queued on each expected read grant.
module tb_gpr_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, rf_rdata;
    logic        init_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rf_mem  [32];
    logic [31:0] exp_mem [32];
    logic [31:0] a_q [$];
    logic [31:0] b_q [$];
    logic        gnt_log [$];
    logic [31:0] a_hold, b_hold;
    logic        tb_last;
    logic        tb_run;
    logic        scramble, poke0;

    always #5 clk = ~clk;

    gpr_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_gnt     (b_gnt),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata),
        .init_done (init_done)
    );

    // Register file with combinational read; scramble fills it with non-zero junk.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'hA500_0000 + i;
        end else if (poke0) begin
            rf_mem[0] <= 32'hFFFF_FFFF;
        end else if (rf_we) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One RUN cycle: inputs already driven at posedge+1, sampled at posedge+4.
    task automatic step();
        logic        ea, eb, we;
        logic [4:0]  addr;
        logic [31:0] wd;
        #3;
        check_eq("a_rvalid", a_rvalid, a_q.size() > 0);
        if (a_q.size() > 0) begin
            a_hold = a_q.pop_front();
            check_eq("a_rdata", a_rdata, a_hold);
        end else check_eq("a_rdata_hold", a_rdata, a_hold);
        check_eq("b_rvalid", b_rvalid, b_q.size() > 0);
        if (b_q.size() > 0) begin
            b_hold = b_q.pop_front();
            check_eq("b_rdata", b_rdata, b_hold);
        end else check_eq("b_rdata_hold", b_rdata, b_hold);
        check_eq("init_done", init_done, 1);
        ea = 1'b0;
        eb = 1'b0;
        if (a_req && b_req) begin
            if (tb_last) ea = 1'b1; else eb = 1'b1;
        end else begin
            ea = a_req;
            eb = b_req;
        end
        check_eq("a_gnt", a_gnt, ea);
        check_eq("b_gnt", b_gnt, eb);
        if (ea || eb) begin
            addr = ea ? a_addr  : b_addr;
            we   = ea ? a_we    : b_we;
            wd   = ea ? a_wdata : b_wdata;
            check_eq("rf_addr", rf_addr, addr);
            if (we) begin
                check_eq("rf_we_wr", rf_we, addr != 0);
                if (addr != 0) begin
                    check_eq("rf_wdata", rf_wdata, wd);
                    exp_mem[addr] = wd;
                end
            end else begin
                check_eq("rf_we_rd", rf_we, 0);
                if (ea) a_q.push_back((addr == 0) ? 32'h0 : exp_mem[addr]);
                else    b_q.push_back((addr == 0) ? 32'h0 : exp_mem[addr]);
            end
            tb_last = eb;
            gnt_log.push_back(eb);
        end else begin
            check_eq("idle_rf_we", rf_we, 0);
            check_eq("idle_rf_addr", rf_addr, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        scramble = 1'b1;
        a_q.delete();
        b_q.delete();
        a_hold  = '0;
        b_hold  = '0;
        tb_last = 1'b1;
        tb_run  = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = '0;
        #1;
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_a_rvalid", a_rvalid, 0);
        check_eq("rst_b_rvalid", b_rvalid, 0);
        check_eq("rst_a_rdata", a_rdata, 0);
        check_eq("rst_b_rdata", b_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        scramble = 1'b0;
        rst_n    = 1'b1;
    endtask

    // Clear sequence with both requesters pushing; nothing may be granted.
    task automatic init_seq();
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd3; a_wdata = 32'h5555_5555;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd4;
        for (int i = 0; i < 32; i++) begin
            #3;
            check_eq("init_rf_we", rf_we, 1);
            check_eq("init_rf_addr", rf_addr, 32'(i));
            check_eq("init_rf_wdata", rf_wdata, 0);
            check_eq("init_a_gnt", a_gnt, 0);
            check_eq("init_b_gnt", b_gnt, 0);
            check_eq("init_done_low", init_done, 0);
            @(posedge clk);
            #1;
        end
        a_req  = 1'b0;
        b_req  = 1'b0;
        tb_run = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; scramble = 1'b1; poke0 = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #1;
        do_reset();
        init_seq();

        // write then read-back on A, and a read of a cleared register
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd5; a_wdata = 32'hDEAD_BEEF;
        step();
        a_we = 1'b0;
        step();
        a_addr = 5'd9;
        step();
        a_req = 1'b0;
        poke0 = 1'b1;
        step();
        poke0 = 1'b0;

        // B write to r0 is swallowed; read of r0 returns zero despite junk in rf
        b_req = 1'b1; b_we = 1'b1; b_addr = 5'd0; b_wdata = 32'h1234_5678;
        step();
        b_we = 1'b0;
        step();
        b_req = 1'b0;
        step();

        // contention: A writes r7, B reads r7, grants must alternate from A
        gnt_log.delete();
        a_req = 1'b1; a_we = 1'b1; a_addr = 5'd7; a_wdata = 32'h100;
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd7;
        for (int k = 0; k < 6; k++) begin
            step();
            if (gnt_log.size() > 0 && gnt_log[gnt_log.size() - 1] == 1'b0) a_wdata = a_wdata + 1;
        end
        a_req = 1'b0; b_req = 1'b0;
        step();
        check_eq("alt_len", gnt_log.size(), 6);
        for (int k = 0; k < 6 && k < gnt_log.size(); k++) check_eq("alt_seq", gnt_log[k], k % 2);

        // lone B while the pointer favours A
        b_req = 1'b1; b_we = 1'b0; b_addr = 5'd5;
        step();
        b_req = 1'b0;
        step();

        // reset while an A read response is in flight
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        #3;
        check_eq("pend_a_gnt", a_gnt, 1);
        a_req = 1'b0;
        do_reset();
        init_seq();
        a_req = 1'b1; a_we = 1'b0; a_addr = 5'd5;
        step();
        a_req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
